mux2_select_scheduler: RTL and testbench



---
 rtl/mux2_select_scheduler_if.sv | 26 ++
 rtl/mux2_select_scheduler.sv | 154 +++++++++++++++
 tb/tb_mux2_select_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mux2_select_scheduler_if.sv
// Request/grant and ttl_74157 control bundle for mux2_select_scheduler.
interface mux2_select_scheduler_if;
  logic [1:0] Request;
  logic [1:0] Grant;
  logic       Select;
  logic       Enable_bar;
  logic       Busy;

  // Requester side: raises requests, observes grant and mux control.
  modport master (
    output Request,
    input  Grant,
    input  Select,
    input  Enable_bar,
    input  Busy
  );

  // Scheduler side.
  modport slave (
    input  Request,
    output Grant,
    output Select,
    output Enable_bar,
    output Busy
  );
endinterface

// File: rtl/mux2_select_scheduler.sv
// Round-robin scheduler sharing one ttl_74157 quad 2:1 mux between requesters
// A (input 0) and B (input 1). Break-before-make: the mux is disabled before
// Select moves and stays disabled for a guard interval before a grant.
module mux2_select_scheduler #(
  parameter int unsigned GUARD_CYCLES = 1,
  parameter int unsigned HOLD_MIN     = 2,
  parameter int unsigned MAX_HOLD     = 8
) (
  input  logic                    Clk,
  input  logic                    Clear,
  mux2_select_scheduler_if.slave  bus
);

  localparam int unsigned GW = 4;
  localparam int unsigned HW = 8;
  localparam logic [HW-1:0] HOLD_SAT = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GUARD   = 2'd1,
    ST_OWN     = 2'd2,
    ST_DISABLE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic [1:0]    grant_q, grant_d;
  logic          en_bar_q, en_bar_d;
  logic          busy_q, busy_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] guard_q, guard_d;

  logic [1:0]    req;
  logic          winner;
  logic          release_c;
  logic          preempt_c;

  assign req = bus.Request;

  // Round-robin pick: sole requester, otherwise whoever was not served last.
  always_comb begin
    winner = ~last_q;
    if (req[0] && !req[1]) begin
      winner = 1'b0;
    end else if (req[1] && !req[0]) begin
      winner = 1'b1;
    end
  end

  // Owner exit conditions; a cycle with both is a single exit.
  always_comb begin
    release_c = !req[sel_q] && (hold_q >= HW'(HOLD_MIN));
    preempt_c = (MAX_HOLD != 0) && req[~sel_q] && (hold_q >= HW'(MAX_HOLD));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    grant_d  = grant_q;
    en_bar_d = en_bar_q;
    last_d   = last_q;
    hold_d   = hold_q;
    guard_d  = guard_q;

    case (state_q)
      ST_IDLE: begin
        grant_d  = 2'b00;
        en_bar_d = 1'b1;
        if (|req) begin
          state_d = ST_GUARD;
          sel_d   = winner;
          guard_d = GW'(GUARD_CYCLES);
        end
      end

      ST_GUARD: begin
        en_bar_d = 1'b1;
        guard_d  = guard_q - GW'(1);
        if (!req[sel_q]) begin
          state_d = ST_IDLE;
        end else if (guard_q <= GW'(1)) begin
          state_d  = ST_OWN;
          grant_d  = sel_q ? 2'b10 : 2'b01;
          en_bar_d = 1'b0;
          last_d   = sel_q;
          hold_d   = HW'(1);
        end
      end

      ST_OWN: begin
        if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HW'(1);
        end
        if (release_c || preempt_c) begin
          state_d  = ST_DISABLE;
          grant_d  = 2'b00;
          en_bar_d = 1'b1;
        end
      end

      ST_DISABLE: begin
        en_bar_d = 1'b1;
        grant_d  = 2'b00;
        if (req[~sel_q]) begin
          state_d = ST_GUARD;
          sel_d   = ~sel_q;
          guard_d = GW'(GUARD_CYCLES);
        end else if (req[sel_q]) begin
          state_d = ST_GUARD;
          guard_d = GW'(GUARD_CYCLES);
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; Clear overrides everything.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      grant_q  <= 2'b00;
      en_bar_q <= 1'b1;
      busy_q   <= 1'b0;
      last_q   <= 1'b1;
      hold_q   <= '0;
      guard_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      grant_q  <= grant_d;
      en_bar_q <= en_bar_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      guard_q  <= guard_d;
    end
  end

  assign bus.Grant      = grant_q;
  assign bus.Select     = sel_q;
  assign bus.Enable_bar = en_bar_q;
  assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_mux2_select_scheduler.sv
// Scoreboard bench for mux2_select_scheduler. Four instances cover the default
// parameters, MAX_HOLD=4, MAX_HOLD=0 and GUARD_CYCLES=3. Expected outputs are
// packed as {Grant[1:0], Select, Enable_bar, Busy}.
module tb_mux2_select_scheduler;

  logic Clk;
  logic Clear;

  mux2_select_scheduler_if if0 ();
  mux2_select_scheduler_if if1 ();
  mux2_select_scheduler_if if2 ();
  mux2_select_scheduler_if if3 ();

  mux2_select_scheduler u_dflt (.Clk(Clk), .Clear(Clear), .bus(if0.slave));
  mux2_select_scheduler #(.MAX_HOLD(4)) u_pre (.Clk(Clk), .Clear(Clear), .bus(if1.slave));
  mux2_select_scheduler #(.MAX_HOLD(0)) u_nopre (.Clk(Clk), .Clear(Clear), .bus(if2.slave));
  mux2_select_scheduler #(.GUARD_CYCLES(3)) u_grd (.Clk(Clk), .Clear(Clear), .bus(if3.slave));

  typedef struct {
    int         dut;
    logic [4:0] exp;
    string      tag;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  n_vec = 0;
  int  n_err = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point for every check.
  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {gnt,sel,enb,busy}=%b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] obs(input int d);
    case (d)
      0:       return {if0.Grant, if0.Select, if0.Enable_bar, if0.Busy};
      1:       return {if1.Grant, if1.Select, if1.Enable_bar, if1.Busy};
      2:       return {if2.Grant, if2.Select, if2.Enable_bar, if2.Busy};
      default: return {if3.Grant, if3.Select, if3.Enable_bar, if3.Busy};
    endcase
  endfunction

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic cyc(input int d, input logic clr, input logic [1:0] req,
                     input logic [4:0] exp, input string tag);
    @(negedge Clk);
    Clear       = clr;
    if0.Request = (d == 0) ? req : 2'b00;
    if1.Request = (d == 1) ? req : 2'b00;
    if2.Request = (d == 2) ? req : 2'b00;
    if3.Request = (d == 3) ? req : 2'b00;
    sb.push_back('{d, exp, tag});
  endtask

  // Compare DUT outputs shortly after each active edge.
  always @(posedge Clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check_eq(mon_e.tag, obs(mon_e.dut), mon_e.exp);
    end
  end

  initial begin
    Clear       = 1'b1;
    if0.Request = 2'b00;
    if1.Request = 2'b00;
    if2.Request = 2'b00;
    if3.Request = 2'b00;

    // Reset with both requesting, then A wins the first tie.
    cyc(0, 1'b1, 2'b11, 5'b00_0_1_0, "t1_rst0");
    cyc(0, 1'b1, 2'b11, 5'b00_0_1_0, "t1_rst1");
    cyc(0, 1'b0, 2'b11, 5'b00_0_1_1, "t1_guard");
    cyc(0, 1'b0, 2'b11, 5'b01_0_0_1, "t1_own_a");
    cyc(0, 1'b0, 2'b00, 5'b01_0_0_1, "t1_hold");
    cyc(0, 1'b0, 2'b00, 5'b00_0_1_1, "t1_dis");
    cyc(0, 1'b0, 2'b00, 5'b00_0_1_0, "t1_idle");

    // Single requester drops early; grant held until HOLD_MIN.
    cyc(0, 1'b0, 2'b01, 5'b00_0_1_1, "t2_guard");
    cyc(0, 1'b0, 2'b01, 5'b01_0_0_1, "t2_own");
    cyc(0, 1'b0, 2'b00, 5'b01_0_0_1, "t2_minhold");
    cyc(0, 1'b0, 2'b00, 5'b00_0_1_1, "t2_dis");
    cyc(0, 1'b0, 2'b00, 5'b00_0_1_0, "t2_idle");

    // Tie, handover A->B, then round-robin on the next tie.
    cyc(0, 1'b1, 2'b00, 5'b00_0_1_0, "t3_rst");
    cyc(0, 1'b0, 2'b11, 5'b00_0_1_1, "t3_guard_a");
    cyc(0, 1'b0, 2'b11, 5'b01_0_0_1, "t3_own_a");
    cyc(0, 1'b0, 2'b11, 5'b01_0_0_1, "t3_hold_a");
    cyc(0, 1'b0, 2'b10, 5'b00_0_1_1, "t3_dis_a");
    cyc(0, 1'b0, 2'b10, 5'b00_1_1_1, "t3_guard_b");
    cyc(0, 1'b0, 2'b10, 5'b10_1_0_1, "t3_own_b");
    cyc(0, 1'b0, 2'b00, 5'b10_1_0_1, "t3_hold_b");
    cyc(0, 1'b0, 2'b00, 5'b00_1_1_1, "t3_dis_b");
    cyc(0, 1'b0, 2'b00, 5'b00_1_1_0, "t3_idle");
    cyc(0, 1'b0, 2'b11, 5'b00_0_1_1, "t3_rr_guard");
    cyc(0, 1'b0, 2'b11, 5'b01_0_0_1, "t3_rr_own_a");
    cyc(0, 1'b0, 2'b00, 5'b01_0_0_1, "t3_cl_hold");
    cyc(0, 1'b0, 2'b00, 5'b00_0_1_1, "t3_cl_dis");
    cyc(0, 1'b0, 2'b00, 5'b00_0_1_0, "t3_cl_idle");

    // Clear while B owns, then A first on a tie.
    cyc(0, 1'b0, 2'b10, 5'b00_1_1_1, "t6_guard_b");
    cyc(0, 1'b0, 2'b10, 5'b10_1_0_1, "t6_own_b");
    cyc(0, 1'b1, 2'b11, 5'b00_0_1_0, "t6_clear");
    cyc(0, 1'b0, 2'b11, 5'b00_0_1_1, "t6_guard_a");
    cyc(0, 1'b0, 2'b11, 5'b01_0_0_1, "t6_own_a");
    cyc(0, 1'b0, 2'b00, 5'b01_0_0_1, "t6_cl_hold");
    cyc(0, 1'b0, 2'b00, 5'b00_0_1_1, "t6_cl_dis");
    cyc(0, 1'b0, 2'b00, 5'b00_0_1_0, "t6_cl_idle");

    // Preemption after MAX_HOLD=4 cycles of ownership.
    cyc(1, 1'b0, 2'b01, 5'b00_0_1_1, "t4_guard_a");
    cyc(1, 1'b0, 2'b01, 5'b01_0_0_1, "t4_own_a1");
    for (int i = 0; i < 3; i++) cyc(1, 1'b0, 2'b11, 5'b01_0_0_1, "t4_own_a");
    cyc(1, 1'b0, 2'b11, 5'b00_0_1_1, "t4_preempt");
    cyc(1, 1'b0, 2'b11, 5'b00_1_1_1, "t4_guard_b");
    cyc(1, 1'b0, 2'b11, 5'b10_1_0_1, "t4_own_b");
    cyc(1, 1'b0, 2'b00, 5'b10_1_0_1, "t4_hold_b");
    cyc(1, 1'b0, 2'b00, 5'b00_1_1_1, "t4_dis_b");
    cyc(1, 1'b0, 2'b00, 5'b00_1_1_0, "t4_idle");

    // Preempt races with the waiter dropping: owner re-acquires.
    cyc(1, 1'b0, 2'b11, 5'b00_0_1_1, "t4r_guard_a");
    cyc(1, 1'b0, 2'b11, 5'b01_0_0_1, "t4r_own_a1");
    for (int i = 0; i < 3; i++) cyc(1, 1'b0, 2'b11, 5'b01_0_0_1, "t4r_own_a");
    cyc(1, 1'b0, 2'b11, 5'b00_0_1_1, "t4r_preempt");
    cyc(1, 1'b0, 2'b01, 5'b00_0_1_1, "t4r_reguard");
    cyc(1, 1'b0, 2'b01, 5'b01_0_0_1, "t4r_reown");
    cyc(1, 1'b0, 2'b00, 5'b01_0_0_1, "t4r_hold");
    cyc(1, 1'b0, 2'b00, 5'b00_0_1_1, "t4r_dis");
    cyc(1, 1'b0, 2'b00, 5'b00_0_1_0, "t4r_idle");

    // MAX_HOLD=0: owner keeps the mux while the other waits.
    cyc(2, 1'b0, 2'b01, 5'b00_0_1_1, "t4n_guard");
    cyc(2, 1'b0, 2'b01, 5'b01_0_0_1, "t4n_own");
    for (int i = 0; i < 10; i++) cyc(2, 1'b0, 2'b11, 5'b01_0_0_1, "t4n_keep");
    cyc(2, 1'b0, 2'b10, 5'b00_0_1_1, "t4n_dis");
    cyc(2, 1'b0, 2'b10, 5'b00_1_1_1, "t4n_guard_b");
    cyc(2, 1'b0, 2'b10, 5'b10_1_0_1, "t4n_own_b");
    cyc(2, 1'b0, 2'b00, 5'b10_1_0_1, "t4n_hold_b");
    cyc(2, 1'b0, 2'b00, 5'b00_1_1_1, "t4n_dis_b");
    cyc(2, 1'b0, 2'b00, 5'b00_1_1_0, "t4n_idle");

    // GUARD_CYCLES=3: abort in guard, then a full three-cycle guard.
    cyc(3, 1'b0, 2'b10, 5'b00_1_1_1, "t5_guard_b");
    cyc(3, 1'b0, 2'b00, 5'b00_1_1_0, "t5_abort");
    cyc(3, 1'b0, 2'b00, 5'b00_1_1_0, "t5_idle");
    cyc(3, 1'b0, 2'b01, 5'b00_0_1_1, "t5_guard1");
    cyc(3, 1'b0, 2'b01, 5'b00_0_1_1, "t5_guard2");
    cyc(3, 1'b0, 2'b01, 5'b00_0_1_1, "t5_guard3");
    cyc(3, 1'b0, 2'b01, 5'b01_0_0_1, "t5_own");
    cyc(3, 1'b0, 2'b00, 5'b01_0_0_1, "t5_hold");
    cyc(3, 1'b0, 2'b00, 5'b00_0_1_1, "t5_dis");
    cyc(3, 1'b0, 2'b00, 5'b00_0_1_0, "t5_idle2");

    // Let the last queued expectations drain.
    repeat (3) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
